remote_controller_param: RTL and testbench
==========================================

Name: remote_controller_param

Overview:
- Parametrised successor to the single-format remote-control serial decoder.
- Decodes one framed serial stream, sampled at one bit per clock: start sequence, custom code, key code, inverted key code.
- Generalises code widths, custom-code checking and the valid-key set.
- Adds per-cause error flags, key-hold repeat detection and a busy indication. Feeds the key-dispatch logic downstream.

Parameters:
CUSTOM_W, 16, custom-code width in bits
KEY_W, 8, key-code width in bits (inverse field has the same width)
CUSTOM_CODE, 16'hAAAA, expected custom code, MSB first
CHECK_CUSTOM, 1, 1 = a custom-code mismatch rejects the frame; 0 = custom code ignored
KEY_VALID_MAP, all ones (2**KEY_W bits), bit k set = key value k is accepted
HOLD_WINDOW, 100, cycles after a valid frame within which an identical key is flagged as repeat
MAX_LOW, 255, maximum consecutive low cycles tolerated in the start sequence

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
serial  input  1  serial frame input; idle high; sampled every rising edge
ready  output  1  one-cycle pulse: valid key accepted
remote_key  output  KEY_W  last accepted key; held until the next accepted frame
repeat  output  1  one-cycle pulse coincident with ready when the key is a hold repeat
err  output  3  one-cycle pulse flags: [0] custom mismatch, [1] inverse mismatch, [2] key not in map
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; ready=0, repeat=0, err=0, remote_key=0, busy=0; shift register, bit counter and hold counter cleared.
- Reset mid-frame aborts the frame immediately; no flags are produced for it.
- Frame format, MSB first: start sequence (one or more low cycles, then exactly one high cycle), CUSTOM_W bits, KEY_W key bits, KEY_W inverse bits.
- Total data bits N = CUSTOM_W + 2*KEY_W.
- FSM states: IDLE, START_LOW, DATA, CHECK.
- IDLE:
  - serial=0 -> START_LOW, low counter = 1.
  - serial=1 -> stay in IDLE.
- START_LOW:
  - serial=1 -> DATA, bit counter = 0.
  - serial=0 -> stay and increment the low counter; when it exceeds MAX_LOW -> IDLE, no flags.
  - Consequence: trailing low bits after a frame merge into the next frame's start sequence. This is legal.
- DATA:
  - Each edge shifts serial into the shift register and increments the bit counter.
  - On the edge that samples bit N-1 -> CHECK.
- CHECK (one cycle, serial ignored), on the edge leaving CHECK:
  - c = custom field != CUSTOM_CODE, and CHECK_CUSTOM=1.
  - i = inverse field != bitwise NOT of key field.
  - m = KEY_VALID_MAP[key] == 0.
  - err <= {m, i, c}. Flags are independent; several may be set together.
  - If c, i and m are all 0: ready <= 1 and remote_key <= key.
  - repeat <= 1 only if the frame is accepted, key == previous remote_key, a previous valid frame exists since reset, and the hold counter < HOLD_WINDOW.
  - State -> IDLE.
- Latency: ready, repeat and err go high in the second cycle after the edge that samples the last inverse bit, and last exactly one cycle.
- A rejected frame leaves remote_key unchanged and does not touch the hold counter.
- Hold counter:
  - Cleared to 0 by each accepted frame.
  - Otherwise increments each cycle, saturating at HOLD_WINDOW.
  - The "previous valid" qualifier is cleared only by reset.
- Back-to-back frames: IDLE is entered one cycle after CHECK. A low on serial in that IDLE cycle begins the next start sequence, so the minimum inter-frame gap is 0 extra cycles.
- busy = (state != IDLE), registered with the state.

Test Plan:
1. Defaults; frame: start 0,1; custom 1010…10; key 00001111; inverse 11110000 -> ready pulse, remote_key=0x0F, err=000, repeat=0.
2. Same frame with inverse 11010010 -> err=010, ready=0, remote_key stays 0x0F.
3. KEY_VALID_MAP with bit 0x0A cleared; key 00001010, inverse 11110101 -> err=100, ready=0, remote_key unchanged.
4. Two valid 0x0F frames separated by 5 low cycles (inside HOLD_WINDOW) -> second gives ready=1, repeat=1. Repeat with a 150-cycle idle-high gap -> repeat=0.
5. Custom code 0x5555: CHECK_CUSTOM=1 -> err=001, no ready. CHECK_CUSTOM=0 -> ready, remote_key=0x0F.
6. Reset asserted mid-key field -> all outputs 0 asynchronously. A subsequent valid frame is accepted normally. A low-only start of 300 cycles -> returns to IDLE, no flags.

Source files
------------

// File: rtl/remote_controller_param_if.sv
// Serial-in / key-out bundle between the remote-control decoder and its environment.
// The source drives serial; the decoder drives the key, pulse and status outputs.
interface remote_controller_param_if #(
  parameter int unsigned KEY_W = 8
) ();
  logic             serial;
  logic             ready;
  logic [KEY_W-1:0] remote_key;
  // Named key_repeat because "repeat" is a reserved word in SystemVerilog.
  logic             key_repeat;
  logic [2:0]       err;
  logic             busy;

  modport slave (
    input  serial,
    output ready, remote_key, key_repeat, err, busy
  );

  modport master (
    output serial,
    input  ready, remote_key, key_repeat, err, busy
  );
endinterface

// File: rtl/remote_controller_param.sv
// Parametrised remote-control frame decoder: start sequence, custom code, key and inverse key,
// with per-cause error flags, key-hold repeat detection and a busy indication.
module remote_controller_param #(
  parameter int unsigned            CUSTOM_W      = 16,
  parameter int unsigned            KEY_W         = 8,
  parameter logic [CUSTOM_W-1:0]    CUSTOM_CODE   = 16'hAAAA,
  parameter bit                     CHECK_CUSTOM  = 1'b1,
  parameter logic [2**KEY_W-1:0]    KEY_VALID_MAP = '1,
  parameter int unsigned            HOLD_WINDOW   = 100,
  parameter int unsigned            MAX_LOW       = 255
) (
  input logic                      clk,
  input logic                      reset,
  remote_controller_param_if.slave bus
);

  localparam int unsigned N     = CUSTOM_W + 2 * KEY_W;
  localparam int unsigned BitW  = $clog2(N);
  localparam int unsigned LowW  = $clog2(MAX_LOW + 2);
  localparam int unsigned HoldW = $clog2(HOLD_WINDOW + 1);

  localparam logic [BitW-1:0]  LastBit = BitW'(N - 1);
  localparam logic [LowW-1:0]  MaxLow  = LowW'(MAX_LOW);
  localparam logic [HoldW-1:0] HoldWin = HoldW'(HOLD_WINDOW);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] START_LOW = 2'd1;
  localparam logic [1:0] DATA      = 2'd2;
  localparam logic [1:0] CHECK     = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [LowW-1:0]  low_q, low_d;
  logic [BitW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]     shift_q, shift_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             prev_q, prev_d;
  logic             ready_q, ready_d;
  logic             rep_q, rep_d;
  logic [2:0]       err_q, err_d;
  logic [KEY_W-1:0] key_q, key_d;

  logic [CUSTOM_W-1:0] custom_f;
  logic [KEY_W-1:0]    key_f, inv_f;
  logic                c_bad, i_bad, m_bad;

  assign custom_f = shift_q[N-1 -: CUSTOM_W];
  assign key_f    = shift_q[2*KEY_W-1 -: KEY_W];
  assign inv_f    = shift_q[KEY_W-1:0];
  assign c_bad    = CHECK_CUSTOM && (custom_f != CUSTOM_CODE);
  assign i_bad    = (inv_f != ~key_f);
  assign m_bad    = ~KEY_VALID_MAP[key_f];

  always_comb begin
    state_d = state_q;
    low_d   = low_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    prev_d  = prev_q;
    key_d   = key_q;
    ready_d = 1'b0;
    rep_d   = 1'b0;
    err_d   = 3'b000;
    hold_d  = (hold_q < HoldWin) ? hold_q + 1'b1 : hold_q;
    case (state_q)
      IDLE: begin
        if (!bus.serial) begin
          state_d = START_LOW;
          low_d   = LowW'(1);
        end
      end
      START_LOW: begin
        if (bus.serial) begin
          state_d = DATA;
          cnt_d   = '0;
        end else if (low_q >= MaxLow) begin
          // Start sequence too long: treat as line noise and drop silently.
          state_d = IDLE;
        end else begin
          low_d = low_q + 1'b1;
        end
      end
      DATA: begin
        shift_d = {shift_q[N-2:0], bus.serial};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastBit) state_d = CHECK;
      end
      CHECK: begin
        state_d = IDLE;
        err_d   = {m_bad, i_bad, c_bad};
        if (!c_bad && !i_bad && !m_bad) begin
          ready_d = 1'b1;
          key_d   = key_f;
          rep_d   = prev_q && (key_f == key_q) && (hold_q < HoldWin);
          prev_d  = 1'b1;
          hold_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      low_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      prev_q  <= 1'b0;
      ready_q <= 1'b0;
      rep_q   <= 1'b0;
      err_q   <= 3'b000;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      low_q   <= low_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      prev_q  <= prev_d;
      ready_q <= ready_d;
      rep_q   <= rep_d;
      err_q   <= err_d;
      key_q   <= key_d;
    end
  end

  assign bus.ready      = ready_q;
  assign bus.key_repeat = rep_q;
  assign bus.err        = err_q;
  assign bus.remote_key = key_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_remote_controller_param.sv
// Directed bench for remote_controller_param: three instances (default, key 0x0A masked,
// custom check disabled) share one serial line and reset.
module tb_remote_controller_param;

  logic clk;
  logic reset;
  logic ser;
  int   checks;
  int   failures;

  localparam logic [255:0] MapB = ~(256'd1 << 10);

  remote_controller_param_if #(.KEY_W(8)) if_a ();
  remote_controller_param_if #(.KEY_W(8)) if_b ();
  remote_controller_param_if #(.KEY_W(8)) if_c ();

  assign if_a.serial = ser;
  assign if_b.serial = ser;
  assign if_c.serial = ser;

  remote_controller_param dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a)
  );

  remote_controller_param #(.KEY_VALID_MAP(MapB)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b)
  );

  remote_controller_param #(.CHECK_CUSTOM(1'b0)) dut_c (
    .clk   (clk),
    .reset (reset),
    .bus   (if_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic b);
    ser = b;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] cust, input logic [7:0] key,
                            input logic [7:0] inv, input int nlow);
    logic [31:0] bits;
    bits = {cust, key, inv};
    for (int i = 0; i < nlow; i++) drive(1'b0);
    drive(1'b1);
    for (int i = 31; i >= 0; i--) drive(bits[i]);
  endtask

  // Pass the CHECK cycle; outputs of the frame are then visible.
  task automatic sample_out();
    drive(1'b1);
  endtask

  initial begin
    logic [31:0] bits;
    int          idle_at;
    int          idle_cnt;
    int          flag_cnt;
    checks   = 0;
    failures = 0;
    ser      = 1'b1;
    reset    = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("rst_ready", {31'd0, if_a.ready}, 32'd0);
    chk("rst_key",   {24'd0, if_a.remote_key}, 32'd0);
    chk("rst_err",   {29'd0, if_a.err}, 32'd0);
    chk("rst_busy",  {31'd0, if_a.busy}, 32'd0);
    chk("rst_rep",   {31'd0, if_a.key_repeat}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // 1: valid frame, key 0x0F
    send_frame(16'hAAAA, 8'h0F, 8'hF0, 1);
    chk("t1_busy_check", {31'd0, if_a.busy}, 32'd1);
    chk("t1_ready_early", {31'd0, if_a.ready}, 32'd0);
    sample_out();
    chk("t1_ready", {31'd0, if_a.ready}, 32'd1);
    chk("t1_key",   {24'd0, if_a.remote_key}, 32'h0F);
    chk("t1_err",   {29'd0, if_a.err}, 32'd0);
    chk("t1_rep",   {31'd0, if_a.key_repeat}, 32'd0);
    chk("t1_busy_idle", {31'd0, if_a.busy}, 32'd0);
    drive(1'b1);
    chk("t1_ready_pulse", {31'd0, if_a.ready}, 32'd0);

    // 2: bad inverse
    send_frame(16'hAAAA, 8'h0F, 8'hD2, 1);
    sample_out();
    chk("t2_err",   {29'd0, if_a.err}, 32'b010);
    chk("t2_ready", {31'd0, if_a.ready}, 32'd0);
    chk("t2_key",   {24'd0, if_a.remote_key}, 32'h0F);
    drive(1'b1);
    chk("t2_err_pulse", {29'd0, if_a.err}, 32'd0);

    // 3: key 0x0A rejected only by the masked instance
    send_frame(16'hAAAA, 8'h0A, 8'hF5, 1);
    sample_out();
    chk("t3_b_err",   {29'd0, if_b.err}, 32'b100);
    chk("t3_b_ready", {31'd0, if_b.ready}, 32'd0);
    chk("t3_b_key",   {24'd0, if_b.remote_key}, 32'h0F);
    chk("t3_a_ready", {31'd0, if_a.ready}, 32'd1);
    chk("t3_a_key",   {24'd0, if_a.remote_key}, 32'h0A);
    chk("t3_a_rep",   {31'd0, if_a.key_repeat}, 32'd0);

    // 4: hold repeat inside and outside the window
    send_frame(16'hAAAA, 8'h0F, 8'hF0, 1);
    sample_out();
    chk("t4a_ready", {31'd0, if_a.ready}, 32'd1);
    chk("t4a_rep",   {31'd0, if_a.key_repeat}, 32'd0);
    send_frame(16'hAAAA, 8'h0F, 8'hF0, 5);
    sample_out();
    chk("t4b_ready", {31'd0, if_a.ready}, 32'd1);
    chk("t4b_rep",   {31'd0, if_a.key_repeat}, 32'd1);
    for (int i = 0; i < 150; i++) drive(1'b1);
    send_frame(16'hAAAA, 8'h0F, 8'hF0, 1);
    sample_out();
    chk("t4c_ready", {31'd0, if_a.ready}, 32'd1);
    chk("t4c_rep",   {31'd0, if_a.key_repeat}, 32'd0);

    // 5: custom code 0x5555
    send_frame(16'h5555, 8'h0F, 8'hF0, 1);
    sample_out();
    chk("t5_a_err",   {29'd0, if_a.err}, 32'b001);
    chk("t5_a_ready", {31'd0, if_a.ready}, 32'd0);
    chk("t5_c_ready", {31'd0, if_c.ready}, 32'd1);
    chk("t5_c_err",   {29'd0, if_c.err}, 32'd0);
    chk("t5_c_key",   {24'd0, if_c.remote_key}, 32'h0F);
    chk("t5_c_rep",   {31'd0, if_c.key_repeat}, 32'd1);

    // 6: reset mid-key field
    bits = {16'hAAAA, 8'h0F, 8'hF0};
    drive(1'b0);
    drive(1'b1);
    for (int i = 31; i >= 12; i--) drive(bits[i]);
    chk("t6_busy_mid", {31'd0, if_a.busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("t6_rst_busy", {31'd0, if_a.busy}, 32'd0);
    chk("t6_rst_key",  {24'd0, if_a.remote_key}, 32'd0);
    chk("t6_rst_err",  {29'd0, if_a.err}, 32'd0);
    ser = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1);
    send_frame(16'hAAAA, 8'h0F, 8'hF0, 1);
    sample_out();
    chk("t6_ready", {31'd0, if_a.ready}, 32'd1);
    chk("t6_key",   {24'd0, if_a.remote_key}, 32'h0F);
    chk("t6_rep",   {31'd0, if_a.key_repeat}, 32'd0);

    // Over-long start: 256th low edge returns to IDLE, then a new start begins.
    idle_at  = 0;
    idle_cnt = 0;
    flag_cnt = 0;
    for (int k = 1; k <= 300; k++) begin
      drive(1'b0);
      if (!if_a.busy) begin
        idle_cnt++;
        idle_at = k;
      end
      if (if_a.ready || (if_a.err != 3'b000)) flag_cnt++;
    end
    chk("t6_low_idle_cnt", idle_cnt, 32'd1);
    chk("t6_low_idle_at",  idle_at,  32'd256);
    chk("t6_low_flags",    flag_cnt, 32'd0);
    reset = 1'b0;
    ser   = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
